vga_system_onchip_memory_dp: RTL and testbench

- Parametrised dual-port on-chip RAM for the VGA system.
- Port s1: Avalon-MM read/write slave, with byte enables, owned by the processor/FFT writer.
- Port s2: read-only scan port for the pixel fetch engine.
- Adds what the single-port RAM lacks: configurable read latency with a readdatavalid pipeline, a second port, mixed-port write-to-read forwarding, and clock-enable freeze of the read pipeline.

---
 rtl/vga_system_onchip_memory_dp.sv | 150 +++++++++++++++
 tb/tb_vga_system_onchip_memory_dp.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_system_onchip_memory_dp.sv
// Dual-port on-chip RAM for the VGA system.
// Port s1 is an Avalon-MM read/write slave with byte enables (processor / FFT
// writer). Port s2 is a read-only scan port for the pixel fetch engine.
// Both ports return data through a readdatavalid pipeline of READ_LATENCY
// (1 or 2) cycles. The whole read pipeline freezes while the effective clock
// enable is low. An s2 read that collides with an s1 write to the same word
// returns the freshly written lanes.
// The RAM image is handed to the FPGA tools through the ram_init_file
// attribute. The array itself is never reset, so written data survives
// reset_n.

module vga_system_onchip_memory_dp #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = "vga_system_onchip_memory2_0.hex"
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    s1_chipselect,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    input  logic                    s2_read,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    input  logic                    clken,
    input  logic                    reset_req
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  en;
    logic                  s1_wr;
    logic                  s1_rd;
    logic                  s2_rd;
    logic                  collide;
    logic [DATA_WIDTH-1:0] be_mask;

    // First read stage: raw array data plus the forwarding overlay for s2.
    logic [DATA_WIDTH-1:0] s1_q;
    logic [DATA_WIDTH-1:0] s2_q;
    logic [DATA_WIDTH-1:0] fwd_mask_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;
    logic                  s1_v1;
    logic                  s2_v1;
    logic [DATA_WIDTH-1:0] s2_d1;

    // A read on s1 is dropped when a write is requested in the same cycle.
    // This keeps the s1 read-during-write case from ever arising.
    assign en      = clken & ~reset_req;
    assign s1_wr   = en & s1_chipselect & s1_write;
    assign s1_rd   = en & s1_chipselect & s1_read & ~s1_write;
    assign s2_rd   = en & s2_read;
    assign collide = s1_wr & (s1_address == s2_address);

    // Expand the s1 byte enables into a per-bit lane mask.
    always_comb begin
        be_mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            be_mask[i*8 +: 8] = {8{s1_byteenable[i]}};
        end
    end

    // Memory array write with byte-lane granularity. It is deliberately not
    // reset, so the contents persist across reset.
    always_ff @(posedge clk) begin
        if (s1_wr) begin
            for (int i = 0; i < BYTES; i++) begin
                if (s1_byteenable[i]) begin
                    mem[s1_address][i*8 +: 8] <= s1_writedata[i*8 +: 8];
                end
            end
        end
    end

    // First read stage. The array is read on each accepted request.
    // Colliding s1 write lanes are captured so that s2 sees the new data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
            s1_v1      <= 1'b0;
            s2_v1      <= 1'b0;
        end else if (en) begin
            s1_v1 <= s1_rd;
            s2_v1 <= s2_rd;
            if (s1_rd) begin
                s1_q <= mem[s1_address];
            end
            if (s2_rd) begin
                s2_q       <= mem[s2_address];
                fwd_mask_q <= collide ? be_mask : '0;
                fwd_data_q <= s1_writedata;
            end
        end
    end

    assign s2_d1 = (s2_q & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q);

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign s1_readdata      = s1_q;
            assign s1_readdatavalid = s1_v1;
            assign s2_readdata      = s2_d1;
            assign s2_readdatavalid = s2_v1;
        end else begin : g_lat2
            logic [DATA_WIDTH-1:0] s1_d2;
            logic [DATA_WIDTH-1:0] s2_d2;
            logic                  s1_v2;
            logic                  s2_v2;

            // Extra output stage. Data only moves with a valid beat, so
            // readdata keeps its last value between beats.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s1_d2 <= '0;
                    s2_d2 <= '0;
                    s1_v2 <= 1'b0;
                    s2_v2 <= 1'b0;
                end else if (en) begin
                    s1_v2 <= s1_v1;
                    s2_v2 <= s2_v1;
                    if (s1_v1) begin
                        s1_d2 <= s1_q;
                    end
                    if (s2_v1) begin
                        s2_d2 <= s2_d1;
                    end
                end
            end

            assign s1_readdata      = s1_d2;
            assign s1_readdatavalid = s1_v2;
            assign s2_readdata      = s2_d2;
            assign s2_readdatavalid = s2_v2;
        end
    endgenerate

endmodule

// File: tb/tb_vga_system_onchip_memory_dp.sv
// Bench for vga_system_onchip_memory_dp.
// It runs a latency-1 instance and a latency-2 instance side by side on
// identical stimulus. Both are compared every cycle against a behavioural
// model. In that model, a read accepted on enabled edge e is visible while
// the count of enabled edges equals e + latency - 1. Readdata keeps the last
// delivered word otherwise.

module tb_vga_system_onchip_memory_dp;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    logic          clk;
    logic          reset_n;
    logic          clken;
    logic          reset_req;
    logic          s1_chipselect;
    logic [AW-1:0] s1_address;
    logic          s1_read;
    logic          s1_write;
    logic [BW-1:0] s1_byteenable;
    logic [DW-1:0] s1_writedata;
    logic          s2_read;
    logic [AW-1:0] s2_address;

    logic [DW-1:0] l1_s1_d, l1_s2_d, l2_s1_d, l2_s2_d;
    logic          l1_s1_v, l1_s2_v, l2_s1_v, l2_s2_v;

    // Stream index k: 0 = lat1 s1, 1 = lat1 s2, 2 = lat2 s1, 3 = lat2 s2.
    logic          act_v [4];
    logic [DW-1:0] act_d [4];
    logic          exp_v [4];
    logic [DW-1:0] exp_d [4];
    logic [DW-1:0] last_d [4];
    resp_t         pend [4][$];
    logic [DW-1:0] mem_m [DEPTH];
    int            en_edges;
    int            checks;
    int            errors;

    vga_system_onchip_memory_dp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_FILE("")
    ) u_lat1 (
        .clk(clk), .reset_n(reset_n),
        .s1_chipselect(s1_chipselect), .s1_address(s1_address),
        .s1_read(s1_read), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(l1_s1_d), .s1_readdatavalid(l1_s1_v),
        .s2_read(s2_read), .s2_address(s2_address),
        .s2_readdata(l1_s2_d), .s2_readdatavalid(l1_s2_v),
        .clken(clken), .reset_req(reset_req)
    );

    vga_system_onchip_memory_dp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .INIT_FILE("")
    ) u_lat2 (
        .clk(clk), .reset_n(reset_n),
        .s1_chipselect(s1_chipselect), .s1_address(s1_address),
        .s1_read(s1_read), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(l2_s1_d), .s1_readdatavalid(l2_s1_v),
        .s2_read(s2_read), .s2_address(s2_address),
        .s2_readdata(l2_s2_d), .s2_readdatavalid(l2_s2_v),
        .clken(clken), .reset_req(reset_req)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Gather the four output streams into arrays for indexed comparison.
    always_comb begin
        act_v[0] = l1_s1_v; act_d[0] = l1_s1_d;
        act_v[1] = l1_s2_v; act_d[1] = l1_s2_d;
        act_v[2] = l2_s1_v; act_d[2] = l2_s1_d;
        act_v[3] = l2_s2_v; act_d[3] = l2_s2_d;
    end

    task automatic set_idle();
        clken         = 1'b1;
        reset_req     = 1'b0;
        s1_chipselect = 1'b0;
        s1_read       = 1'b0;
        s1_write      = 1'b0;
        s1_address    = '0;
        s1_byteenable = '0;
        s1_writedata  = '0;
        s2_read       = 1'b0;
        s2_address    = '0;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            pend[k].delete();
            last_d[k] = '0;
            exp_v[k]  = 1'b0;
            exp_d[k]  = '0;
        end
    endtask

    // Apply the effect of one clock edge to the model.
    // Instance d has latency d + 1.
    task automatic model_edge();
        resp_t r;
        if (!reset_n) begin
            model_clear();
            return;
        end
        if (clken && !reset_req) begin
            en_edges++;
            if (s1_chipselect && s1_write) begin
                for (int b = 0; b < BW; b++) begin
                    if (s1_byteenable[b]) mem_m[s1_address][b*8 +: 8] = s1_writedata[b*8 +: 8];
                end
            end
            for (int d = 0; d < 2; d++) begin
                if (s1_chipselect && s1_read && !s1_write) begin
                    r.due  = en_edges + d;
                    r.data = mem_m[s1_address];
                    pend[2*d].push_back(r);
                end
                if (s2_read) begin
                    r.due  = en_edges + d;
                    r.data = mem_m[s2_address];
                    pend[2*d+1].push_back(r);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            while (pend[k].size() > 0 && pend[k][0].due < en_edges) void'(pend[k].pop_front());
            exp_v[k] = 1'b0;
            if (pend[k].size() > 0 && pend[k][0].due == en_edges) begin
                exp_v[k]  = 1'b1;
                last_d[k] = pend[k][0].data;
            end
            exp_d[k] = last_d[k];
        end
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_prefill();
        for (int a = 0; a < DEPTH; a++) begin
            set_idle();
            s1_chipselect = 1'b1;
            s1_write      = 1'b1;
            s1_address    = AW'(a);
            s1_byteenable = '1;
            s1_writedata  = $urandom;
            run_cycle();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k] || act_d[k] !== exp_d[k]) begin
                    errors++;
                    $display("[TB] FAIL prefill stream%0d got v=%b d=%h want v=%b d=%h", k, act_v[k], act_d[k], exp_v[k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] kick [3];
        set_idle();
        s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = '0;
        s1_byteenable = '1;   s1_writedata = 32'hC0FFEE00;
        run_cycle();
        for (int i = 0; i < 2; i++) begin
            set_idle();
            s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = AW'(5 + 2*i);
            s2_read = 1'b1; s2_address = AW'(6 + 2*i);
            run_cycle();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k] || act_d[k] !== exp_d[k]) begin
                    errors++;
                    $display("[TB] FAIL pre_reset stream%0d got v=%b d=%h want v=%b d=%h", k, act_v[k], act_d[k], exp_v[k], exp_d[k]);
                end
            end
        end
        set_idle();
        #3 reset_n = 1'b0;
        #1;
        model_clear();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (act_v[k] !== 1'b0 || act_d[k] !== 32'h0) begin
                errors++;
                $display("[TB] FAIL async_reset stream%0d got v=%b d=%h want v=0 d=0", k, act_v[k], act_d[k]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            run_cycle();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k] || act_d[k] !== exp_d[k]) begin
                    errors++;
                    $display("[TB] FAIL in_reset stream%0d got v=%b d=%h want v=%b d=%h", k, act_v[k], act_d[k], exp_v[k], exp_d[k]);
                end
            end
        end
        #2 reset_n = 1'b1;
        kick[0] = 4'd1; kick[1] = 4'd0; kick[2] = 4'd0;
        for (int i = 0; i < 3; i++) begin
            set_idle();
            s1_chipselect = kick[i][0]; s1_read = kick[i][0]; s1_address = '0;
            run_cycle();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k] || act_d[k] !== exp_d[k]) begin
                    errors++;
                    $display("[TB] FAIL post_reset stream%0d got v=%b d=%h want v=%b d=%h", k, act_v[k], act_d[k], exp_v[k], exp_d[k]);
                end
            end
            checks++;
            if ((i == 0 && (l1_s1_v !== 1'b1 || l1_s1_d !== 32'hC0FFEE00)) ||
                (i == 1 && (l2_s1_v !== 1'b1 || l2_s1_d !== 32'hC0FFEE00)) ||
                (i == 2 && (l1_s1_v !== 1'b0 || l2_s1_v !== 1'b0))) begin
                errors++;
                $display("[TB] FAIL reset_read0 step%0d got l1 v=%b d=%h l2 v=%b d=%h want word C0FFEE00", i, l1_s1_v, l1_s1_d, l2_s1_v, l2_s1_d);
            end
        end
    endtask

    task automatic test_byte_enables();
        for (int i = 0; i < 4; i++) begin
            set_idle();
            s1_chipselect = 1'b1; s1_address = AW'(16);
            if (i == 0) begin s1_write = 1'b1; s1_byteenable = 4'hF;    s1_writedata = 32'hAABBCCDD; end
            if (i == 1) begin s1_write = 1'b1; s1_byteenable = 4'b0101; s1_writedata = 32'h11223344; end
            if (i == 2) s1_read = 1'b1;
            if (i == 3) s1_chipselect = 1'b0;
            run_cycle();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k] || act_d[k] !== exp_d[k]) begin
                    errors++;
                    $display("[TB] FAIL byteen stream%0d got v=%b d=%h want v=%b d=%h", k, act_v[k], act_d[k], exp_v[k], exp_d[k]);
                end
            end
            if (i >= 2) begin
                checks++;
                if ((i == 2 && (l1_s1_v !== 1'b1 || l1_s1_d !== 32'hAA22CC44)) ||
                    (i == 3 && (l2_s1_v !== 1'b1 || l2_s1_d !== 32'hAA22CC44))) begin
                    errors++;
                    $display("[TB] FAIL byteen_merge step%0d got l1 %b/%h l2 %b/%h want AA22CC44", i, l1_s1_v, l1_s1_d, l2_s1_v, l2_s1_d);
                end
            end
        end
    endtask

    task automatic test_collision();
        for (int i = 0; i < 4; i++) begin
            set_idle();
            if (i == 0) begin
                s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = AW'(256);
                s1_byteenable = 4'hF; s1_writedata = 32'h01234567;
            end
            if (i == 1) begin
                s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = AW'(256);
                s1_byteenable = 4'b1100; s1_writedata = 32'hDEADBEEF;
                s2_read = 1'b1; s2_address = AW'(256);
            end
            if (i == 2) begin s2_read = 1'b1; s2_address = AW'(256); end
            run_cycle();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k] || act_d[k] !== exp_d[k]) begin
                    errors++;
                    $display("[TB] FAIL collision stream%0d got v=%b d=%h want v=%b d=%h", k, act_v[k], act_d[k], exp_v[k], exp_d[k]);
                end
            end
            if (i >= 1) begin
                checks++;
                if ((i == 1 && (l1_s2_v !== 1'b1 || l1_s2_d !== 32'hDEAD4567)) ||
                    (i == 2 && (l2_s2_v !== 1'b1 || l2_s2_d !== 32'hDEAD4567)) ||
                    (i == 3 && (l2_s2_v !== 1'b1 || l2_s2_d !== 32'hDEAD4567))) begin
                    errors++;
                    $display("[TB] FAIL collision_fwd step%0d got l1 %b/%h l2 %b/%h want DEAD4567", i, l1_s2_v, l1_s2_d, l2_s2_v, l2_s2_d);
                end
            end
        end
    endtask

    task automatic test_streaming();
        int cnt1 = 0;
        int cnt2 = 0;
        for (int i = 0; i < 258; i++) begin
            set_idle();
            if (i < 256) begin
                s2_read = 1'b1; s2_address = AW'(i);
                if (i % 2 == 1) begin
                    s1_chipselect = 1'b1; s1_read = 1'b1;
                    s1_address = AW'($urandom_range(0, DEPTH - 1));
                end
            end
            run_cycle();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k] || act_d[k] !== exp_d[k]) begin
                    errors++;
                    $display("[TB] FAIL stream cyc%0d stream%0d got v=%b d=%h want v=%b d=%h", i, k, act_v[k], act_d[k], exp_v[k], exp_d[k]);
                end
            end
            if (l1_s2_v === 1'b1) cnt1++;
            if (l2_s2_v === 1'b1) cnt2++;
        end
        checks++;
        if (cnt1 != 256 || cnt2 != 256) begin
            errors++;
            $display("[TB] FAIL stream_count got lat1=%0d lat2=%0d want 256", cnt1, cnt2);
        end
    endtask

    task automatic test_freeze();
        logic [AW-1:0] addr;
        logic [DW-1:0] old;
        addr = AW'(51);
        old  = mem_m[addr];
        for (int i = 0; i < 8; i++) begin
            set_idle();
            if (i == 0 || i == 6) begin s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = addr; end
            if (i >= 1 && i <= 3) begin
                if (i == 2) reset_req = 1'b1;
                else clken = 1'b0;
                s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = addr;
                s1_byteenable = '1; s1_writedata = ~old;
                s2_read = 1'b1; s2_address = AW'(i);
            end
            run_cycle();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k] || act_d[k] !== exp_d[k]) begin
                    errors++;
                    $display("[TB] FAIL freeze cyc%0d stream%0d got v=%b d=%h want v=%b d=%h", i, k, act_v[k], act_d[k], exp_v[k], exp_d[k]);
                end
            end
            if (i == 3 || i == 6) begin
                checks++;
                if (l1_s1_v !== 1'b1 || l1_s1_d !== old) begin
                    errors++;
                    $display("[TB] FAIL freeze_hold cyc%0d got v=%b d=%h want v=1 d=%h", i, l1_s1_v, l1_s1_d, old);
                end
            end
        end
    endtask

    task automatic test_rw_same();
        for (int i = 0; i < 4; i++) begin
            set_idle();
            s1_chipselect = 1'b1; s1_address = AW'(512);
            if (i == 0) begin
                s1_read = 1'b1; s1_write = 1'b1;
                s1_byteenable = 4'hF; s1_writedata = 32'h5A5A5A5A;
            end
            if (i == 2) s1_read = 1'b1;
            run_cycle();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k] || act_d[k] !== exp_d[k]) begin
                    errors++;
                    $display("[TB] FAIL rw_same stream%0d got v=%b d=%h want v=%b d=%h", k, act_v[k], act_d[k], exp_v[k], exp_d[k]);
                end
            end
            checks++;
            if ((i <= 1 && (l1_s1_v !== 1'b0 || l2_s1_v !== 1'b0)) ||
                (i == 2 && (l1_s1_v !== 1'b1 || l1_s1_d !== 32'h5A5A5A5A)) ||
                (i == 3 && (l2_s1_v !== 1'b1 || l2_s1_d !== 32'h5A5A5A5A))) begin
                errors++;
                $display("[TB] FAIL rw_same_result step%0d got l1 %b/%h l2 %b/%h want 5A5A5A5A", i, l1_s1_v, l1_s1_d, l2_s1_v, l2_s1_d);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_idle();
            clken         = ($urandom_range(0, 9) != 0);
            reset_req     = ($urandom_range(0, 19) == 0);
            s1_chipselect = ($urandom_range(0, 3) != 0);
            s1_read       = 1'($urandom);
            s1_write      = ($urandom_range(0, 2) == 0);
            s1_byteenable = BW'($urandom);
            s1_writedata  = $urandom;
            s1_address    = AW'($urandom_range(0, 31));
            s2_read       = 1'($urandom);
            s2_address    = ($urandom_range(0, 1) == 0) ? s1_address : AW'($urandom_range(0, 31));
            run_cycle();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k] || act_d[k] !== exp_d[k]) begin
                    errors++;
                    $display("[TB] FAIL random cyc%0d stream%0d got v=%b d=%h want v=%b d=%h", i, k, act_v[k], act_d[k], exp_v[k], exp_d[k]);
                end
            end
        end
    endtask

    // Abort if the sequence ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    // Main sequence.
    initial begin
        checks   = 0;
        errors   = 0;
        en_edges = 0;
        set_idle();
        reset_n = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        test_prefill();
        test_reset();
        test_byte_enables();
        test_collision();
        test_streaming();
        test_freeze();
        test_rw_same();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
